// File: rtl/analog_snapshot_pkg.sv
// analog_snapshot_pkg: shared sizes, FSM states and snapshot type for the analog status snapshot block
package analog_snapshot_pkg;
  localparam int STATUS_W = 32;
  localparam int N_STATUS = 4;
  typedef enum logic [2:0] {IDLE, REQ, SETTLE, CAPTURE, RELEASE, ABORT} state_t;
  typedef logic [N_STATUS-1:0][STATUS_W-1:0] status_t;
endpackage

// File: rtl/tech_sync.sv
// tech_sync: multi-flop synchronizer for a single asynchronous bit
module tech_sync #(
  parameter int SYNC_DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic [SYNC_DEPTH-1:0] ff;
  // shift the asynchronous input through the flop chain
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ff <= '0;
    else ff <= {ff[SYNC_DEPTH-2:0], d};
  assign q = ff[SYNC_DEPTH-1];
endmodule

// File: rtl/analog_status_snapshot.sv
// analog_status_snapshot: coherent req/ack capture of four analog status words; change IRQ under ANALOG_SNAPSHOT_CHANGE_IRQ_EN
module analog_status_snapshot
  import analog_snapshot_pkg::*;
#(
  parameter int PERIOD_CYCLES  = 1024,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_W          = 16
) (
  input  logic                clk_in,
  input  logic                reset_n,
  input  logic                trigger_i,
  input  logic                auto_en_i,
  input  logic                clear_i,
  input  logic                analog_ack_i,
  input  logic [STATUS_W-1:0] analog_data_0_i,
  input  logic [STATUS_W-1:0] analog_data_1_i,
  input  logic [STATUS_W-1:0] analog_data_2_i,
  input  logic [STATUS_W-1:0] analog_data_3_i,
  output logic                analog_req_o,
  output logic [STATUS_W-1:0] status_0,
  output logic [STATUS_W-1:0] status_1,
  output logic [STATUS_W-1:0] status_2,
  output logic [STATUS_W-1:0] status_3,
  output logic [CNT_W-1:0]    snap_count_o,
  output logic                busy_o,
  output logic                timeout_o,
  output logic                change_irq_o
);
  localparam int PW = PERIOD_CYCLES > 1 ? $clog2(PERIOD_CYCLES) : 1;
  localparam int TW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;

  state_t        state, state_n;
  status_t       snap, data;
  logic          ack_s, pending, tick, req_set, go, tfire, ready;
  logic [PW-1:0] pcnt;
  logic [TW-1:0] tcnt;
  logic [2:0]    low_cnt;

  tech_sync #(.SYNC_DEPTH(2)) u_ack_sync (
    .clk   (clk_in),
    .rst_n (reset_n),
    .d     (analog_ack_i),
    .q     (ack_s)
  );

  assign data    = {analog_data_3_i, analog_data_2_i, analog_data_1_i, analog_data_0_i};
  assign {status_3, status_2, status_1, status_0} = snap;
  assign busy_o  = state != IDLE;
  assign tick    = auto_en_i && PERIOD_CYCLES > 0 && pcnt == PW'(PERIOD_CYCLES - 1);
  assign req_set = trigger_i | tick;
  assign ready   = low_cnt[2];
  assign go      = state == IDLE && ready && (pending || req_set);
  assign tfire   = tcnt == TW'(TIMEOUT_CYCLES - 1);

  // next-state decode of the four-phase handshake
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    state_n = go ? REQ : IDLE;
      REQ:     state_n = ack_s ? SETTLE : (tfire ? ABORT : REQ);
      SETTLE:  state_n = CAPTURE;
      CAPTURE: state_n = RELEASE;
      RELEASE: state_n = !ack_s ? IDLE : (tfire ? ABORT : RELEASE);
      ABORT:   state_n = ack_s ? ABORT : IDLE;
      default: state_n = IDLE;
    endcase
  end

  // state, registered request and per-state timeout counter
  always_ff @(posedge clk_in or negedge reset_n)
    if (!reset_n) begin
      state        <= IDLE;
      analog_req_o <= 1'b0;
      tcnt         <= '0;
    end else begin
      state        <= state_n;
      analog_req_o <= state_n inside {REQ, SETTLE, CAPTURE};
      tcnt         <= (state_n != state || !(state inside {REQ, RELEASE})) ? '0 : tcnt + 1'b1;
    end

  // period timer, collapsing request flag and post-reset ack-low qualification
  // (the first two low samples after reset are the synchronizer flushing, so four are required)
  always_ff @(posedge clk_in or negedge reset_n)
    if (!reset_n) begin
      pcnt    <= '0;
      pending <= 1'b0;
      low_cnt <= '0;
    end else begin
      pcnt    <= (!auto_en_i || PERIOD_CYCLES == 0 || tick) ? '0 : pcnt + 1'b1;
      pending <= (pending | req_set) & ~go;
      low_cnt <= ready ? low_cnt : (ack_s ? '0 : low_cnt + 1'b1);
    end

  // coherent capture of all four words, sequence count and sticky timeout (set wins over clear)
  always_ff @(posedge clk_in or negedge reset_n)
    if (!reset_n) begin
      snap         <= '0;
      snap_count_o <= '0;
      timeout_o    <= 1'b0;
    end else begin
      snap         <= state == CAPTURE ? data : snap;
      snap_count_o <= snap_count_o + CNT_W'(state == CAPTURE);
      timeout_o    <= state == ABORT || (timeout_o && !clear_i);
    end

`ifdef ANALOG_SNAPSHOT_CHANGE_IRQ_EN
  // one-cycle pulse when the new snapshot differs from the held one
  always_ff @(posedge clk_in or negedge reset_n)
    if (!reset_n) change_irq_o <= 1'b0;
    else change_irq_o <= state == CAPTURE && data != snap;
`else
  assign change_irq_o = 1'b0;
`endif
endmodule
